// File: rtl/data_memory_responder.sv
// Data-memory responder: fixed-latency RV32I load/store engine over an internal word array.
// Optional MEM_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses instead of masking them.
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned LATENCY      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] memory_address,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [31:0] memory_write_data,
    input  logic [2:0]  funct3,
    output logic [31:0] memory_read_data,
    output logic        memory_ready,
    output logic        memory_error
);

    localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
    localparam int unsigned CntW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] ByteSpan = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       mem_q [DEPTH_WORDS];

    logic [31:0]       off;
    logic [IdxW-1:0]   idx;
    logic [1:0]        lane;
    logic              acc_err, size_err, misalign_err;
    logic [31:0]       cur_word, load_data, store_data, store_mask;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic              commit;

    always_comb begin
        off      = addr_q - BASE_ADDRESS;
        idx      = off[IdxW+1:2];
        lane     = addr_q[1:0];
        cur_word = mem_q[idx];

        if (rd_q) size_err = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11);
        else      size_err = funct3_q[2] || (funct3_q[1:0] == 2'b11);

`ifdef MEM_MISALIGN_TRAP_EN
        misalign_err = ((funct3_q[1:0] == 2'b01) && lane[0]) ||
                       ((funct3_q[1:0] == 2'b10) && (lane != 2'b00));
`else
        misalign_err = 1'b0;
`endif

        acc_err = (addr_q < BASE_ADDRESS) || ({1'b0, off} >= ByteSpan) ||
                  (rd_q && wr_q) || size_err || misalign_err;

        byte_sel = 8'(cur_word >> {lane, 3'b000});
        half_sel = lane[1] ? cur_word[31:16] : cur_word[15:0];

        // funct3[2] selects zero extension for LBU/LHU
        case (funct3_q[1:0])
            2'b00: begin
                load_data  = {{24{~funct3_q[2] & byte_sel[7]}}, byte_sel};
                store_data = {4{wdata_q[7:0]}};
                store_mask = 32'h0000_00FF << {lane, 3'b000};
            end
            2'b01: begin
                load_data  = {{16{~funct3_q[2] & half_sel[15]}}, half_sel};
                store_data = {2{wdata_q[15:0]}};
                store_mask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            end
            default: begin
                load_data  = cur_word;
                store_data = wdata_q;
                store_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        commit   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (memory_read || memory_write) begin
                    addr_d   = memory_address;
                    wdata_d  = memory_write_data;
                    funct3_d = funct3;
                    rd_d     = memory_read;
                    wr_d     = memory_write;
                    cnt_d    = CntW'(LATENCY - 1);
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    err_d   = acc_err;
                    rdata_d = (acc_err || !rd_q) ? 32'h0 : load_data;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Storage is never cleared; reset only suppresses a pending commit.
    always_ff @(posedge clk) begin
        if (rst_n && commit && wr_q && !acc_err) begin
            mem_q[idx] <= (cur_word & ~store_mask) | (store_data & store_mask);
        end
    end

    assign memory_ready     = (state_q == StResp);
    assign memory_read_data = rdata_q;
    assign memory_error     = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed scoreboard bench for data_memory_responder (BASE=0, DEPTH=1024, LATENCY=2).
module tb_data_memory_responder;

    localparam int unsigned Lat = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] memory_address;
    logic        memory_read;
    logic        memory_write;
    logic [31:0] memory_write_data;
    logic [2:0]  funct3;
    logic [31:0] memory_read_data;
    logic        memory_ready;
    logic        memory_error;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    data_memory_responder #(
        .DEPTH_WORDS (1024),
        .BASE_ADDRESS(32'h0000_0000),
        .LATENCY     (Lat)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .memory_address   (memory_address),
        .memory_read      (memory_read),
        .memory_write     (memory_write),
        .memory_write_data(memory_write_data),
        .funct3           (funct3),
        .memory_read_data (memory_read_data),
        .memory_ready     (memory_ready),
        .memory_error     (memory_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic access(input string tag, input logic [31:0] addr, input logic rd,
                          input logic wr, input logic [31:0] wd, input logic [2:0] f3,
                          input logic [31:0] exp_d, input logic exp_e, input bit toggle);
        exp_t e;
        int   cycles;
        bit   seen;
        @(negedge clk);
        memory_address    = addr;
        memory_read       = rd;
        memory_write      = wr;
        memory_write_data = wd;
        funct3            = f3;
        e.tag  = tag;
        e.data = exp_d;
        e.err  = exp_e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        memory_read       = toggle;
        memory_write      = toggle;
        memory_address    = 32'h0000_0010;
        memory_write_data = 32'hA5A5_A5A5;
        funct3            = 3'b010;
        cycles = 0;
        seen   = 1'b0;
        while (cycles < 20) begin
            @(negedge clk);
            if (memory_ready) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            cycles++;
        end
        memory_read  = 1'b0;
        memory_write = 1'b0;
        check({tag, " ready"}, 32'(seen), 32'd1);
        if (seen) begin
            e = sb.pop_front();
            check({e.tag, " data"}, memory_read_data, e.data);
            check({e.tag, " err"}, 32'(memory_error), 32'(e.err));
            check({e.tag, " latency"}, cycles, Lat);
            @(negedge clk);
            check({e.tag, " pulse"}, 32'(memory_ready), 32'd0);
            check({e.tag, " hold"}, memory_read_data, e.data);
        end
    endtask

    initial begin
        logic [31:0] misalign_d;
        logic        misalign_e;
        bit          any_ready;
        rst_n             = 1'b0;
        memory_address    = '0;
        memory_read       = 1'b0;
        memory_write      = 1'b0;
        memory_write_data = '0;
        funct3            = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", 32'(memory_ready), 32'd0);
        check("reset data", memory_read_data, 32'h0);
        check("reset err", 32'(memory_error), 32'd0);
        rst_n = 1'b1;

        access("SW 10", 32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0, 1'b0);
        access("LW 10", 32'h10, 1'b1, 1'b0, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, 1'b0);
        access("SB 13", 32'h13, 1'b0, 1'b1, 32'h0000_0080, 3'b000, 32'h0, 1'b0, 1'b0);
        access("LB 13", 32'h13, 1'b1, 1'b0, 32'h0, 3'b000, 32'hFFFF_FF80, 1'b0, 1'b0);
        access("LBU 13", 32'h13, 1'b1, 1'b0, 32'h0, 3'b100, 32'h0000_0080, 1'b0, 1'b0);
        access("LW 10b", 32'h10, 1'b1, 1'b0, 32'h0, 3'b010, 32'h80AD_BEEF, 1'b0, 1'b0);
        access("SH 10", 32'h10, 1'b0, 1'b1, 32'hFFFF_1234, 3'b001, 32'h0, 1'b0, 1'b0);
        access("LH 12", 32'h12, 1'b1, 1'b0, 32'h0, 3'b001, 32'hFFFF_80AD, 1'b0, 1'b0);
        access("LHU 10 tog", 32'h10, 1'b1, 1'b0, 32'h0, 3'b101, 32'h0000_1234, 1'b0, 1'b1);
        access("LW 10c", 32'h10, 1'b1, 1'b0, 32'h0, 3'b010, 32'h80AD_1234, 1'b0, 1'b0);
        access("LW oor", 32'h1000, 1'b1, 1'b0, 32'h0, 3'b010, 32'h0, 1'b1, 1'b0);
        access("SW oor", 32'h1000, 1'b0, 1'b1, 32'h1, 3'b010, 32'h0, 1'b1, 1'b0);
        access("RW both", 32'h10, 1'b1, 1'b1, 32'hFFFF_FFFF, 3'b010, 32'h0, 1'b1, 1'b0);
        access("LW 10d", 32'h10, 1'b1, 1'b0, 32'h0, 3'b010, 32'h80AD_1234, 1'b0, 1'b0);
        access("L f3=011", 32'h10, 1'b1, 1'b0, 32'h0, 3'b011, 32'h0, 1'b1, 1'b0);
        access("S f3=100", 32'h10, 1'b0, 1'b1, 32'hFFFF_FFFF, 3'b100, 32'h0, 1'b1, 1'b0);
        access("LW 10e", 32'h10, 1'b1, 1'b0, 32'h0, 3'b010, 32'h80AD_1234, 1'b0, 1'b0);

`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d = 32'h0;
        misalign_e = 1'b1;
`else
        misalign_d = 32'h80AD_1234;
        misalign_e = 1'b0;
`endif
        access("LW 11 misalign", 32'h11, 1'b1, 1'b0, 32'h0, 3'b010, misalign_d, misalign_e,
               1'b0);

        access("SW 20", 32'h20, 1'b0, 1'b1, 32'h0, 3'b010, 32'h0, 1'b0, 1'b0);
        access("LW 10f", 32'h10, 1'b1, 1'b0, 32'h0, 3'b010, 32'h80AD_1234, 1'b0, 1'b0);

        // Store aborted by reset while in WAIT
        @(negedge clk);
        memory_address    = 32'h20;
        memory_write      = 1'b1;
        memory_write_data = 32'h55;
        funct3            = 3'b010;
        @(posedge clk);
        #1;
        memory_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        any_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (memory_ready) any_ready = 1'b1;
        end
        check("abort data", memory_read_data, 32'h0);
        check("abort err", 32'(memory_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (memory_ready) any_ready = 1'b1;
        end
        check("abort no ready", 32'(any_ready), 32'd0);
        access("LW 20", 32'h20, 1'b1, 1'b0, 32'h0, 3'b010, 32'h0, 1'b0, 1'b0);

        check("scoreboard empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
